// File: rtl/bbox_frame_sequencer.sv
// Host-facing sequencer for the bounding-box engine.
// Decodes 32-bit host writes into image-RAM byte writes or a start command,
// pulses the engine start, guards the run with a watchdog and latches the
// min/max result into a packed read word.
// Ports:
//   CLOCK_50, reset          : clock, synchronous active-high reset
//   wr_en, hex_value_index   : host write ([31:24] data, [23:0] index/command)
//   rd_en, coordinates       : host read strobe and registered read data
//   busy                     : high while the engine owns the RAM
//   ram_we/ram_addr/ram_wdata: image RAM byte write port
//   bb_start, bb_done, bb_*  : engine start pulse, completion and result
module bbox_frame_sequencer #(
  parameter int unsigned WIDTH          = 100,
  parameter int unsigned HEIGHT         = 100,
  parameter int unsigned BPP            = 3,
  parameter int unsigned BBRESET        = 99999,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] hex_value_index,
  input  logic        rd_en,
  output logic [31:0] coordinates,
  output logic        busy,
  output logic        ram_we,
  output logic [14:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        bb_start,
  input  logic        bb_done,
  input  logic [7:0]  bb_xmin,
  input  logic [7:0]  bb_ymin,
  input  logic [7:0]  bb_xmax,
  input  logic [7:0]  bb_ymax
);

  localparam int unsigned TOTAL = WIDTH * HEIGHT * BPP;
  localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_W = 24;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       box_q, box_d;
  logic [31:0]       coord_q, coord_d;
  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic [14:0]       addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              start_q, start_d;

  logic [23:0] idx_c;
  logic [7:0]  byte_c;
  logic        is_pix_c;
  logic        is_cmd_c;
  logic        host_owns_c;

  assign idx_c       = hex_value_index[23:0];
  assign byte_c      = hex_value_index[31:24];
  assign is_pix_c    = idx_c < 24'(TOTAL);
  assign is_cmd_c    = idx_c == 24'(BBRESET);
  assign host_owns_c = (state_q == S_IDLE) || (state_q == S_RESULT);

  // Next-state, write decode, watchdog and read-word selection
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    box_d   = box_q;
    coord_d = coord_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    // Host byte writes only while the engine is not using the RAM
    if (wr_en && is_pix_c && host_owns_c) begin
      we_d    = 1'b1;
      addr_d  = idx_c[14:0];
      wdata_d = byte_c;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (wr_en && is_cmd_c) begin
          state_d = S_START;
          err_d   = 1'b0;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        wd_d    = '0;
      end
      S_WAIT: begin
        // Done takes priority over a coincident watchdog expiry
        if (bb_done) begin
          box_d   = {bb_xmin, bb_ymin, bb_xmax, bb_ymax};
          state_d = S_RESULT;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_RESULT: begin
        // Reading the box closes the frame; a same-cycle counted write is dropped
        if (rd_en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bit31 set marks a status word; a valid box never has it set
    if (rd_en) begin
      coord_d = (state_q == S_RESULT) ? box_q
                                      : {1'b1, err_q, state_q, 4'b0, cnt_q};
    end

    busy_d  = (state_d == S_START) || (state_d == S_WAIT);
    start_d = (state_d == S_START);
  end

  // State and output registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      box_q   <= '0;
      coord_q <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      box_q   <= box_d;
      coord_q <= coord_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
    end
  end

  assign coordinates = coord_q;
  assign busy        = busy_q;
  assign ram_we      = we_q;
  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign bb_start    = start_q;

endmodule
